psk_tx_core: RTL and testbench

// Parametrised PSK transmit core: byte stream in (valid/ready), DAC sample stream out. Successor to the fixed BPSK

---
 rtl/psk_pkg.sv | 43 ++++
 rtl/psk_tx_core_sine_lut.sv | 72 +++++++
 rtl/psk_tx_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_psk_tx_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared types, quadrant constants and helpers for the PSK transmit core.
package psk_pkg;

    // Modulation selected per byte (sampled when the byte is loaded).
    typedef enum logic {
        MODE_BPSK = 1'b0,
        MODE_QPSK = 1'b1
    } psk_mode_e;

    // Transmit sequencer states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } psk_state_e;

    // Carrier phase quadrants; the offset into the sine table is quadrant * (table size / 4).
    localparam logic [1:0] QUAD_0   = 2'd0;
    localparam logic [1:0] QUAD_90  = 2'd1;
    localparam logic [1:0] QUAD_180 = 2'd2;
    localparam logic [1:0] QUAD_270 = 2'd3;

    // Symbols carried by one byte in each mode.
    localparam int BPSK_SYMBOLS = 8;
    localparam int QPSK_SYMBOLS = 4;

    // Mid-scale code of an unsigned offset-binary DAC of the given width.
    function automatic int unsigned mid_scale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    // Gray-coded dibit to quadrant: 00->0, 01->90, 11->180, 10->270 degrees.
    function automatic logic [1:0] qpsk_gray(input logic [1:0] dibit);
        logic [1:0] quad;
        case (dibit)
            2'b00:   quad = QUAD_0;
            2'b01:   quad = QUAD_90;
            2'b11:   quad = QUAD_180;
            default: quad = QUAD_270;
        endcase
        return quad;
    endfunction

endpackage

// File: rtl/psk_tx_core_sine_lut.sv
// Registered sine ROM: one full carrier period, offset-binary around mid-scale.
// The table contents are computed at elaboration time from a Taylor series.
module psk_sine_lut
    import psk_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_BITS  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  clr,
    input  logic [ADDR_BITS-1:0]  addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(mid_scale(DATA_WIDTH));

    // MID + round((MID-1) * sin(2*pi*k/DEPTH)), rounding half away from zero.
    function automatic logic [DATA_WIDTH-1:0] sine_entry(input int k);
        real pi_c;
        real x;
        real term;
        real sum;
        real scaled;
        int  mid_i;
        int  rounded;
        pi_c  = 3.14159265358979323846;
        mid_i = int'(mid_scale(DATA_WIDTH));
        x     = 2.0 * pi_c * real'(k) / real'(DEPTH);
        // Fold into [-pi, pi] so the series converges quickly.
        if (x > pi_c) begin
            x = x - 2.0 * pi_c;
        end
        term = x;
        sum  = x;
        for (int n = 1; n < 24; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        scaled = real'(mid_i - 1) * sum;
        if (scaled >= 0.0) begin
            rounded = $rtoi(scaled + 0.5);
        end else begin
            rounded = -$rtoi(0.5 - scaled);
        end
        return DATA_WIDTH'(mid_i + rounded);
    endfunction

    logic [DATA_WIDTH-1:0] rom [DEPTH];
    logic [DATA_WIDTH-1:0] data_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY = sine_entry(gi);
        assign rom[gi] = ENTRY;
    end

    // Registered read; clr parks the output at mid-scale when no sample is being produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= MID;
        end else if (rd_en) begin
            data_reg <= rom[addr];
        end else if (clr) begin
            data_reg <= MID;
        end
    end

    assign data = data_reg;

endmodule

// File: rtl/psk_tx_core.sv
// PSK transmit core: byte FIFO, BPSK/QPSK symbol sequencer, phase accumulator and sine-LUT carrier.
module psk_tx_core
    import psk_pkg::*;
#(
    parameter int DATA_WIDTH         = 12,
    parameter int FIFO_DEPTH         = 16,
    parameter int CLKS_PER_SAMPLE    = 4,
    parameter int SAMPLES_PER_SYMBOL = 8,
    parameter int LUT_ADDR_BITS      = 6,
    parameter int CARRIER_STEP       = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic                               mode,
    input  logic                               enable,
    output logic [DATA_WIDTH-1:0]              sample,
    output logic                               sample_valid,
    output logic                               symbol_strobe,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int TICK_W  = $clog2(CLKS_PER_SAMPLE);
    localparam int SPS_W   = $clog2(SAMPLES_PER_SYMBOL);

    localparam logic [TICK_W-1:0]        TICK_MAX  = TICK_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [SPS_W-1:0]         SAMP_MAX  = SPS_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [LUT_ADDR_BITS-1:0] STEP      = LUT_ADDR_BITS'(CARRIER_STEP);
    localparam logic [2:0]               BPSK_LAST = 3'(BPSK_SYMBOLS - 1);
    localparam logic [2:0]               QPSK_LAST = 3'(QPSK_SYMBOLS - 1);

    // ------------------------------------------------------------------
    // Sample tick generator
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;

    assign tick = (tick_cnt_reg == TICK_MAX);

    // Free-running divider; the tick is the last count of each sample period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LEVEL_W-1:0] level_reg;
    logic               push;
    logic               pop;
    logic               has_byte;
    logic [7:0]         fifo_head;

    assign s_ready    = (level_reg != LEVEL_W'(FIFO_DEPTH));
    assign push       = s_valid & s_ready;
    assign has_byte   = (level_reg != '0);
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    assign fifo_level = level_reg;

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= s_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Symbol sequencer
    // ------------------------------------------------------------------
    psk_state_e               state_reg, state_next;
    logic [7:0]               byte_reg, byte_next;
    psk_mode_e                mode_reg, mode_next;
    logic [2:0]               sym_idx_reg, sym_idx_next;
    logic [SPS_W-1:0]         samp_cnt_reg, samp_cnt_next;
    logic [LUT_ADDR_BITS-1:0] acc_reg, acc_next;
    logic                     sample_valid_reg;
    logic                     symbol_strobe_reg;
    logic                     emit;
    logic                     lut_clr;
    logic                     last_sample;
    logic                     last_symbol;
    logic [1:0]               quadrant;
    logic [LUT_ADDR_BITS-1:0] offset;
    logic [LUT_ADDR_BITS-1:0] lut_addr;

    assign last_sample = (samp_cnt_reg == SAMP_MAX);
    assign last_symbol = (mode_reg == MODE_QPSK) ? (sym_idx_reg == QPSK_LAST)
                                                 : (sym_idx_reg == BPSK_LAST);

    // Phase quadrant of the current symbol; bytes are sent LSB first.
    always_comb begin
        quadrant = QUAD_0;
        if (mode_reg == MODE_QPSK) begin
            quadrant = qpsk_gray(byte_reg[{sym_idx_reg[1:0], 1'b0} +: 2]);
        end else begin
            quadrant = byte_reg[sym_idx_reg] ? QUAD_180 : QUAD_0;
        end
    end

    assign offset   = LUT_ADDR_BITS'(quadrant) << (LUT_ADDR_BITS - 2);
    assign lut_addr = acc_reg + offset;

    // State, byte and position registers of the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            byte_reg     <= '0;
            mode_reg     <= MODE_BPSK;
            sym_idx_reg  <= '0;
            samp_cnt_reg <= '0;
            acc_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            byte_reg     <= byte_next;
            mode_reg     <= mode_next;
            sym_idx_reg  <= sym_idx_next;
            samp_cnt_reg <= samp_cnt_next;
            acc_reg      <= acc_next;
        end
    end

    // Next-state logic: loads bytes on ticks, steps samples and symbols, chains bytes without a gap.
    always_comb begin
        state_next    = state_reg;
        byte_next     = byte_reg;
        mode_next     = mode_reg;
        sym_idx_next  = sym_idx_reg;
        samp_cnt_next = samp_cnt_reg;
        acc_next      = acc_reg;
        pop           = 1'b0;
        emit          = 1'b0;
        lut_clr       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    lut_clr = 1'b1;
                    if (enable && has_byte) begin
                        pop           = 1'b1;
                        byte_next     = fifo_head;
                        mode_next     = psk_mode_e'(mode);
                        sym_idx_next  = '0;
                        samp_cnt_next = '0;
                        acc_next      = '0;
                        state_next    = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (tick) begin
                    emit     = 1'b1;
                    acc_next = acc_reg + STEP;
                    if (last_sample) begin
                        samp_cnt_next = '0;
                        if (last_symbol) begin
                            // Chain straight into the next byte; the carrier phase keeps running.
                            if (enable && has_byte) begin
                                pop          = 1'b1;
                                byte_next    = fifo_head;
                                mode_next    = psk_mode_e'(mode);
                                sym_idx_next = '0;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end else begin
                            sym_idx_next = sym_idx_reg + 1'b1;
                        end
                    end else begin
                        samp_cnt_next = samp_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output pulses aligned with the registered LUT read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid_reg  <= 1'b0;
            symbol_strobe_reg <= 1'b0;
        end else begin
            sample_valid_reg  <= emit;
            symbol_strobe_reg <= emit && (samp_cnt_reg == '0);
        end
    end

    psk_sine_lut #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (LUT_ADDR_BITS)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_en (emit),
        .clr   (lut_clr),
        .addr  (lut_addr),
        .data  (sample)
    );

    assign sample_valid  = sample_valid_reg;
    assign symbol_strobe = symbol_strobe_reg;
    assign busy          = (state_reg == ST_ACTIVE);

endmodule

// File: tb/tb_psk_tx_core.sv
// Directed bench for psk_tx_core with default parameters (MID = 2048).
module tb_psk_tx_core;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mode;
    logic        enable;
    logic [11:0] sample;
    logic        sample_valid;
    logic        symbol_strobe;
    logic        busy;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int samples[$];
    int strobes[$];

    // Carrier values at phase addresses 0,8,..,56 of the 64-entry table.
    int tbl[8] = '{2048, 3495, 4095, 3495, 2048, 601, 1, 601};

    psk_tx_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .mode          (mode),
        .enable        (enable),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .symbol_strobe (symbol_strobe),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Capture emitted samples and strobe times on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid) samples.push_back(int'(sample));
            if (symbol_strobe) begin
                strobes.push_back(cycle);
                checks++;
                if (sample_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL strobe_with_valid: sample_valid=%0b required 1", sample_valid);
                end
            end
        end
    end

    // Expected n-th sample of a byte: 8 samples per symbol, quadrant shifts the table by 2 entries.
    function automatic int exp_sample(input logic [7:0] b, input bit qpsk, input int n);
        int sym;
        int quad;
        logic [1:0] d;
        sym = n / 8;
        if (qpsk) begin
            d = {b[2*sym+1], b[2*sym]};
            case (d)
                2'b00:   quad = 0;
                2'b01:   quad = 1;
                2'b11:   quad = 2;
                default: quad = 3;
            endcase
        end else begin
            quad = b[sym] ? 2 : 0;
        end
        return tbl[((n % 8) + 2 * quad) % 8];
    endfunction

    task automatic push_byte(input logic [7:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (s_ready) begin
            s_data  = b;
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            ok      = 1'b1;
            $display("push byte 0x%02h level=%0d", b, fifo_level);
        end
    endtask

    task automatic wait_busy(input logic val, input int limit, output bit ok);
        int n;
        n = 0;
        while (busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === val);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        samples.delete();
        strobes.delete();
        repeat (40) @(negedge clk);
        checks++; if (samples.size() !== 0) begin errors++; $display("FAIL reset_no_valid: pulses=%0d required 0", samples.size()); end
        checks++; if (sample !== 12'd2048) begin errors++; $display("FAIL reset_sample: got %0d required 2048", sample); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b required 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
        $display("test_reset done");
    endtask

    task automatic test_bpsk_single();
        bit ok;
        mode   = 1'b0;
        enable = 1'b1;
        samples.delete();
        strobes.delete();
        push_byte(8'h01, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bpsk_push: accepted=%0b required 1", ok); end
        wait_busy(1'b1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bpsk_busy_rise: busy=%0b required 1", busy); end
        // Mode change mid-byte must not affect the byte in flight.
        mode = 1'b1;
        wait_busy(1'b0, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bpsk_busy_fall: busy=%0b required 0", busy); end
        mode = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (samples.size() !== 64) begin errors++; $display("FAIL bpsk_count: samples=%0d required 64", samples.size()); end
        checks++; if (strobes.size() !== 8) begin errors++; $display("FAIL bpsk_strobes: strobes=%0d required 8", strobes.size()); end
        if (strobes.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (strobes[i] - strobes[i-1] !== 32) begin errors++; $display("FAIL bpsk_spacing: strobe %0d gap=%0d required 32", i, strobes[i] - strobes[i-1]); end
            end
        end
        if (samples.size() == 64) begin
            checks++; if (samples[0] !== 2048) begin errors++; $display("FAIL bpsk_s0_0: got %0d required 2048", samples[0]); end
            checks++; if (samples[1] !== 601)  begin errors++; $display("FAIL bpsk_s0_1: got %0d required 601", samples[1]); end
            checks++; if (samples[8] !== 2048) begin errors++; $display("FAIL bpsk_s1_0: got %0d required 2048", samples[8]); end
            checks++; if (samples[9] !== 3495) begin errors++; $display("FAIL bpsk_s1_1: got %0d required 3495", samples[9]); end
            for (int n = 0; n < 64; n++) begin
                checks++;
                if (samples[n] !== exp_sample(8'h01, 1'b0, n)) begin errors++; $display("FAIL bpsk_seq: sample %0d got %0d required %0d", n, samples[n], exp_sample(8'h01, 1'b0, n)); end
            end
        end
        checks++; if (sample !== 12'd2048) begin errors++; $display("FAIL bpsk_idle_mid: got %0d required 2048", sample); end
        $display("test_bpsk_single done");
    endtask

    task automatic test_qpsk();
        bit ok;
        int first[4] = '{2048, 1, 4095, 2048};
        mode   = 1'b1;
        enable = 1'b1;
        samples.delete();
        strobes.delete();
        push_byte(8'h1B, ok);
        wait_busy(1'b1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL qpsk_busy_rise: busy=%0b required 1", busy); end
        wait_busy(1'b0, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL qpsk_busy_fall: busy=%0b required 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (strobes.size() !== 4) begin errors++; $display("FAIL qpsk_strobes: strobes=%0d required 4", strobes.size()); end
        checks++; if (samples.size() !== 32) begin errors++; $display("FAIL qpsk_count: samples=%0d required 32", samples.size()); end
        if (samples.size() == 32) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if (samples[8*s] !== first[s]) begin errors++; $display("FAIL qpsk_first: symbol %0d got %0d required %0d", s, samples[8*s], first[s]); end
            end
        end
        $display("test_qpsk done");
    endtask

    task automatic test_fifo_full();
        bit ok;
        mode   = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(i), ok);
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d required 16", fifo_level); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b required 0", s_ready); end
        s_data  = 8'hAA;
        s_valid = 1'b1;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_no_push: got %0d required 16", fifo_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle: busy=%0b required 0", busy); end
        samples.delete();
        strobes.delete();
        enable = 1'b1;
        begin
            int n;
            n = 0;
            while (fifo_level !== 5'd15 && n < 20) begin @(negedge clk); n++; end
        end
        checks++; if (fifo_level !== 5'd15) begin errors++; $display("FAIL first_pop_level: got %0d required 15", fifo_level); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_pop_busy: got %0b required 1", busy); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL first_pop_ready: got %0b required 1", s_ready); end
        // Dropping enable lets the current byte finish, then the core idles.
        enable = 1'b0;
        wait_busy(1'b0, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drain_busy_fall: busy=%0b required 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (samples.size() !== 64) begin errors++; $display("FAIL drain_count: samples=%0d required 64", samples.size()); end
        checks++; if (fifo_level !== 5'd15) begin errors++; $display("FAIL drain_level: got %0d required 15", fifo_level); end
        if (samples.size() == 64) begin
            checks++; if (samples[1] !== 3495) begin errors++; $display("FAIL drain_s0_1: got %0d required 3495", samples[1]); end
            checks++; if (samples[58] !== 4095) begin errors++; $display("FAIL drain_s7_2: got %0d required 4095", samples[58]); end
        end
        $display("test_fifo_full done");
    endtask

    task automatic test_reset_mid_byte();
        int n;
        samples.delete();
        strobes.delete();
        enable = 1'b1;
        n = 0;
        while (strobes.size() < 4 && n < 400) begin @(negedge clk); n++; end
        checks++; if (strobes.size() < 4) begin errors++; $display("FAIL midrst_reach_sym3: strobes=%0d required 4", strobes.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sample !== 12'd2048) begin errors++; $display("FAIL midrst_sample: got %0d required 2048", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b required 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b required 0", busy); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL midrst_level: got %0d required 0", fifo_level); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b required 1", s_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        samples.delete();
        strobes.delete();
        repeat (60) @(negedge clk);
        checks++; if (samples.size() !== 0) begin errors++; $display("FAIL midrst_stale: pulses=%0d required 0", samples.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_post_busy: got %0b required 0", busy); end
        checks++; if (sample !== 12'd2048) begin errors++; $display("FAIL midrst_post_sample: got %0d required 2048", sample); end
        $display("test_reset_mid_byte done");
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] b;
        mode   = 1'b0;
        enable = 1'b0;
        push_byte(8'h01, ok);
        push_byte(8'hFE, ok);
        samples.delete();
        strobes.delete();
        enable = 1'b1;
        wait_busy(1'b1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_busy_rise: busy=%0b required 1", busy); end
        wait_busy(1'b0, 1200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_busy_fall: busy=%0b required 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (strobes.size() !== 16) begin errors++; $display("FAIL b2b_strobes: strobes=%0d required 16", strobes.size()); end
        checks++; if (samples.size() !== 128) begin errors++; $display("FAIL b2b_count: samples=%0d required 128", samples.size()); end
        if (strobes.size() == 16) begin
            for (int i = 1; i < 16; i++) begin
                checks++;
                if (strobes[i] - strobes[i-1] !== 32) begin errors++; $display("FAIL b2b_spacing: strobe %0d gap=%0d required 32", i, strobes[i] - strobes[i-1]); end
            end
        end
        if (samples.size() == 128) begin
            for (int n = 0; n < 128; n++) begin
                b = (n < 64) ? 8'h01 : 8'hFE;
                checks++;
                if (samples[n] !== exp_sample(b, 1'b0, n % 64)) begin errors++; $display("FAIL b2b_seq: sample %0d got %0d required %0d", n, samples[n], exp_sample(b, 1'b0, n % 64)); end
            end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        mode    = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        test_reset();
        test_bpsk_single();
        test_qpsk();
        test_fifo_full();
        test_reset_mid_byte();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
